fibo_result_checker: RTL

FIBO_RESULT_CHECKER -- requirements
Module: fibo_result_checker

---
 rtl/fibo_result_checker_if.sv | 12 +
 rtl/fibo_result_checker.sv | 119 +++++++++++
 2 files changed

// File: rtl/fibo_result_checker_if.sv
// Data-memory read port used by the Fibonacci result checker.
// The checker is the master: it issues a read and samples rd_data one cycle later.
interface fibo_result_checker_if #(
  parameter int DATA_W = 64
);
  logic              rd_en;
  logic [63:0]       rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/fibo_result_checker.sv
// Scans data memory words 1..N_TERMS after a CPU halt and checks them against
// the Fibonacci sequence f(1)=f(2)=1; reports pass or the first failing index.
//
// state | meaning
// IDLE  | waiting for a halt rising edge
// ISSUE | read request for word idx
// CHECK | compare returned word with the expected term
// DONE  | result held until the next halt rising edge
module fibo_result_checker #(
  parameter int N_TERMS = 20,
  parameter int DATA_W  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   halt,
  fibo_result_checker_if.master  mem,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [7:0]             fail_idx
);

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK, DONE} state_t;

  localparam logic [7:0]        IDX_LAST = 8'(N_TERMS);
  localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

  state_t            state, state_d;
  logic              halt_q;
  logic [7:0]        idx, idx_d;
  logic [DATA_W-1:0] exp_prv1, exp_prv1_d;
  logic [DATA_W-1:0] exp_prv2, exp_prv2_d;
  logic              pass_q, pass_d;
  logic [7:0]        fail_q, fail_d;
  logic [DATA_W-1:0] expected;
  logic              start;

  assign start    = halt & ~halt_q;
  assign pass     = pass_q;
  assign fail_idx = fail_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      halt_q   <= 1'b0;
      idx      <= '0;
      exp_prv1 <= '0;
      exp_prv2 <= '0;
      pass_q   <= 1'b0;
      fail_q   <= '0;
    end else begin
      state    <= state_d;
      halt_q   <= halt;
      idx      <= idx_d;
      exp_prv1 <= exp_prv1_d;
      exp_prv2 <= exp_prv2_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
    end
  end

  always_comb begin
    state_d     = state;
    idx_d       = idx;
    exp_prv1_d  = exp_prv1;
    exp_prv2_d  = exp_prv2;
    pass_d      = pass_q;
    fail_d      = fail_q;
    mem.rd_en   = 1'b0;
    mem.rd_addr = '0;
    busy        = 1'b0;
    done        = 1'b0;
    expected    = (idx == 8'd1) ? ONE : exp_prv1 + exp_prv2;

    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          state_d    = ISSUE;
          idx_d      = 8'd1;
          exp_prv2_d = '0;
          exp_prv1_d = ONE;
          pass_d     = 1'b0;
          fail_d     = '0;
        end
      end
      ISSUE: begin
        busy        = 1'b1;
        mem.rd_en   = 1'b1;
        mem.rd_addr = 64'(idx);
        state_d     = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (mem.rd_data == expected) begin
          if (idx == IDX_LAST) begin
            state_d = DONE;
            pass_d  = 1'b1;
            fail_d  = '0;
          end else begin
            // Word 1 is the seed itself; shifting here would double-count it.
            if (idx != 8'd1) begin
              exp_prv2_d = exp_prv1;
              exp_prv1_d = expected;
            end
            idx_d   = idx + 8'd1;
            state_d = ISSUE;
          end
        end else begin
          state_d = DONE;
          pass_d  = 1'b0;
          fail_d  = idx;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
